seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (range 2..8).
REQ-002 SHALL have parameter PRESCALE, default 1000, clock cycles each digit is driven (minimum 2).
REQ-003 SHALL have parameter BLINK_DIV, default 64, frames per blink half-period (used only when SEG7_BLINK_EN is defined).
REQ-004 SHALL have port Clk, input, 1, system clock; one clock, all state on its rising edge.
REQ-005 SHALL have port Reset, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port Value, input, 4*NUM_DIGITS, hex nibbles; nibble i drives digit i, digit 0 least significant.
REQ-007 SHALL have port Load, input, 1, one-cycle strobe that captures Value into the pending register.
REQ-008 SHALL have port BlankMask, input, NUM_DIGITS, per-digit force-blank.
REQ-009 SHALL have port LzsEn, input, 1, leading-zero suppression enable.
REQ-010 SHALL have port BlinkMask, input, NUM_DIGITS, per-digit blink enable; present only with SEG7_BLINK_EN.
REQ-011 SHALL have port Seg, output, 7 ([0:6]), segments a..g, active-low, Seg[0]=a.
REQ-012 SHALL have port DigitSel, output, NUM_DIGITS, one-hot active-low digit enable.
REQ-013 SHALL have port FrameDone, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-014 SHALL use segment patterns 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000, blank=1111111.
REQ-015 SHALL count PrescaleCnt 0..PRESCALE-1 and wrap; a tick SHALL occur in the cycle PrescaleCnt==PRESCALE-1.
REQ-016 SHALL on each tick advance DigitIdx by 1, wrapping NUM_DIGITS-1 to 0.
REQ-017 SHALL register Seg and DigitSel; in the cycle after a tick they SHALL show the new DigitIdx (latency 1 cycle from tick).
REQ-018 SHALL drive DigitSel with only bit DigitIdx low, all other bits high.
REQ-019 SHALL treat a tick with DigitIdx==NUM_DIGITS-1 as a frame boundary: copy pending into the active register if pending is valid, clear the valid flag, and pulse FrameDone for one cycle after it.
REQ-020 SHALL on Load write Value to pending and set valid; a later Load before the boundary SHALL overwrite it (last wins).
REQ-021 SHALL on Load in the same cycle as a frame boundary copy that cycle's Value directly into active and leave valid clear.
REQ-022 SHALL blank digit i when BlankMask[i]=1, regardless of the other controls.
REQ-023 SHALL with LzsEn=1 blank digit i (i>0) when active nibble i and all more-significant nibbles are zero; digit 0 SHALL never be LZS-blanked.
REQ-024 SHALL sample BlankMask and LzsEn combinationally at each digit update; they SHALL NOT be frame-synchronised.

Reset
REQ-025 SHALL on Reset asynchronously set PrescaleCnt=0, DigitIdx=0, active=0, pending=0, valid=0, Seg=1111111, DigitSel all ones, FrameDone=0.
REQ-026 SHALL on Reset asserted mid-frame or mid-Load discard the pending value; the first tick after release SHALL select digit 1.

Configuration
REQ-027 SHALL with SEG7_BLINK_EN defined count frames modulo BLINK_DIV and toggle BlinkPhase (reset 0) on wrap; digits with BlinkMask[i]=1 SHALL be blank while BlinkPhase=1.
REQ-028 SHALL without SEG7_BLINK_EN omit the BlinkMask port, the blink counter and BlinkPhase, and behave as if BlinkPhase were always 0.

Structure
REQ-029 SHALL place SEG_BLANK (7'b1111111), the 16-entry segment pattern table and a seg_t typedef (logic [0:6]) in package seg7_pkg.
REQ-030 SHALL implement the nibble-to-pattern lookup as combinational sub-module seg7_hex_lut, instantiated once on the selected nibble.

Verification (NUM_DIGITS=4, PRESCALE=4)
REQ-031 SHALL check reset: Reset pulse -> Seg=1111111, DigitSel=1111, FrameDone=0; after release DigitSel walks 1101,1011,0111,1110 every 4 cycles.
REQ-032 SHALL check load timing: Load with Value=16'h1A3F mid-frame -> display unchanged until FrameDone, then digits 0..3 show 0111000, 0000110, 0001000, 1001111.
REQ-033 SHALL check LZS: Value=16'h0040, LzsEn=1 -> digits 3 and 2 blank, digit 1 = 1001100, digit 0 = 0000001; Value=16'h0000 -> only digit 0 lit (0000001).
REQ-034 SHALL check load collisions: two Loads (16'h1111 then 16'h2222) in one frame -> only 2222 shown; Load 16'h5555 on the boundary cycle -> 5555 shown in the next frame.
REQ-035 SHALL check blanking: BlankMask=4'b0101 with Value=16'h8888 -> digits 0 and 2 show 1111111, digits 1 and 3 show 0000000.
REQ-036 SHALL check blink, with SEG7_BLINK_EN and BLINK_DIV=2: BlinkMask=4'b0001 -> digit 0 alternates lit/blank every 2 frames.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// seg_t is indexed a..g as [0:6]; all patterns are active-low (0 = segment lit).
package seg7_pkg;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Hex glyphs 0..F; lower-case b and d keep them distinct from 8 and 0.
  localparam seg_t SEG_TABLE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational nibble-to-segment lookup.
// Ports: nibble (hex digit in), seg_c (active-low a..g pattern out).
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg_c
);

  always_comb seg_c = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered display value,
// per-digit blanking and leading-zero suppression.
// Optional feature: define SEG7_BLINK_EN to add the BlinkMask port and a
// frame-based blink phase (BLINK_DIV frames per half-period).
// Ports:
//   Clk, Reset     - clock, asynchronous active-high reset
//   Value, Load    - hex nibbles (digit 0 in bits 3:0) and capture strobe
//   BlankMask      - per-digit force blank
//   LzsEn          - leading-zero suppression enable
//   BlinkMask      - per-digit blink enable (SEG7_BLINK_EN only)
//   Seg            - active-low segments, Seg[0] = a
//   DigitSel       - one-hot active-low digit enable
//   FrameDone      - one-cycle pulse after each frame boundary
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 1000,
  parameter int unsigned BLINK_DIV  = 64
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic                    Load,
  input  logic [NUM_DIGITS-1:0]   BlankMask,
  input  logic                    LzsEn,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   BlinkMask,
`endif
  output logic [0:6]              Seg,
  output logic [NUM_DIGITS-1:0]   DigitSel,
  output logic                    FrameDone
);

  localparam int unsigned VW = 4 * NUM_DIGITS;
  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  logic [PW-1:0]         prescale_cnt_q, prescale_cnt_d;
  logic [IW-1:0]         digit_idx_q, digit_idx_d;
  logic [VW-1:0]         active_q, active_d;
  logic [VW-1:0]         pending_q, pending_d;
  logic                  valid_q, valid_d;
  seg_t                  seg_q, seg_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick;
  logic                  boundary;
  logic [3:0]            sel_nibble;
  logic                  zero_above;
  logic [NUM_DIGITS-1:0] lzs_blank;
  logic                  blink_blank;
  logic                  digit_blank;
  seg_t                  lut_seg_c;

  // Prescaler, digit scan and pending/active double buffer.
  always_comb begin
    tick           = (prescale_cnt_q == PW'(PRESCALE - 1));
    boundary       = tick && (digit_idx_q == IW'(NUM_DIGITS - 1));
    prescale_cnt_d = tick ? '0 : prescale_cnt_q + PW'(1);
    digit_idx_d    = digit_idx_q;
    active_d       = active_q;
    pending_d      = pending_q;
    valid_d        = valid_q;
    frame_done_d   = boundary;

    if (tick) begin
      digit_idx_d = boundary ? '0 : digit_idx_q + IW'(1);
    end

    // A Load coinciding with the boundary bypasses pending entirely.
    if (boundary) begin
      valid_d = 1'b0;
      if (Load) begin
        active_d = Value;
      end else if (valid_q) begin
        active_d = pending_q;
      end
    end else if (Load) begin
      pending_d = Value;
      valid_d   = 1'b1;
    end
  end

  // Nibble of the digit about to be shown, and leading-zero blank flags.
  // Both look at active_d so the first digit of a new frame shows new data.
  always_comb begin
    sel_nibble = '0;
    zero_above = 1'b1;
    lzs_blank  = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (digit_idx_d == IW'(i)) begin
        sel_nibble = active_d[4*i +: 4];
      end
    end
    // Walk down from the most significant digit; digit 0 is never suppressed.
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      zero_above   = zero_above && (active_d[4*i +: 4] == 4'h0);
      lzs_blank[i] = LzsEn && zero_above;
    end
  end

  seg7_hex_lut u_hex_lut (
    .nibble (sel_nibble),
    .seg_c  (lut_seg_c)
  );

`ifdef SEG7_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  // Frame counter modulo BLINK_DIV; phase flips on each wrap.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (boundary) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
    blink_blank = BlinkMask[digit_idx_d] && blink_phase_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  assign blink_blank = 1'b0;
`endif

  assign digit_blank = BlankMask[digit_idx_d] || lzs_blank[digit_idx_d] || blink_blank;

  // Segment and digit-select outputs only change on a scan tick.
  always_comb begin
    seg_d       = seg_q;
    digit_sel_d = digit_sel_q;
    if (tick) begin
      seg_d       = digit_blank ? SEG_BLANK : lut_seg_c;
      digit_sel_d = ~(SEL_ONE << digit_idx_d);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prescale_cnt_q <= '0;
      digit_idx_q    <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      valid_q        <= 1'b0;
      seg_q          <= SEG_BLANK;
      digit_sel_q    <= '1;
      frame_done_q   <= 1'b0;
    end else begin
      prescale_cnt_q <= prescale_cnt_d;
      digit_idx_q    <= digit_idx_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      valid_q        <= valid_d;
      seg_q          <= seg_d;
      digit_sel_q    <= digit_sel_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign Seg       = seg_q;
  assign DigitSel  = digit_sel_q;
  assign FrameDone = frame_done_q;

endmodule
